brightness_stream_ctrl: RTL and testbench
=========================================

// Module: brightness_stream_ctrl
// PURPOSE
//  Frame-level sequencer and 2-stage pipeline around the 4-lane brightness datapath.
//  Accepts 32-bit words (4 x 8-bit pixels) from the frame reader over valid/ready.
//  Applies a signed, saturating brightness offset and streams results to the writer.
//  The offset is latched only at frame start, so config writes never tear a frame.
// PARAMETERS
//  CNT_W    16  width of per-frame word counter
//  BETA_W    8  width of signed brightness offset (two's complement)
// PORTS
//  clk          in   1       system clock, rising edge
//  n_rst        in   1       asynchronous, active-low reset
//  cfg_we       in   1       write strobe for cfg_beta/cfg_en into pending regs
//  cfg_beta     in   BETA_W  signed offset, -128..127
//  cfg_en       in   1       1 = apply offset, 0 = bypass (offset forced to 0)
//  frame_start  in   1       pulse: begin frame, latch pending config
//  in_valid     in   1       input word valid
//  in_data      in   32      pixels {p0,p1,p2,p3}, p0 in [31:24]
//  in_last      in   1       marks last word of frame (qualified by in_valid&in_ready)
//  in_ready     out  1       block accepts word this cycle
//  out_valid    out  1       output word valid
//  out_data     out  32      adjusted pixels, same lane order
//  out_last     out  1       last word of frame, travels with its data
//  out_ready    in   1       downstream accepts word
//  busy         out  1       state != IDLE
//  frame_done   out  1       1-cycle pulse when last word leaves out port
//  word_cnt     out  CNT_W   words accepted in current/last frame
// BEHAVIOUR
//  Reset (n_rst=0, async): state=IDLE, all pipe valids=0, in_ready=0, out_valid=0,
//   out_data=0, out_last=0, frame_done=0, word_cnt=0, pending/active beta=0, en=0.
//  FSM: IDLE -frame_start-> RUN -in_last accepted-> DRAIN -pipe empty-> IDLE.
//   frame_start ignored in RUN/DRAIN. cfg_we and frame_start same cycle: new value
//   is latched into active regs for that frame. cfg_we in RUN/DRAIN only updates pending.
//  On frame_start: word_cnt cleared to 0; increments on each accepted input word;
//   saturates at all-ones (no wrap).
//  Pipeline: S1 registers in_data/in_last; S2 registers saturated result/last.
//   adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2.
//   in_ready = (state==RUN) & adv1. Latency in->out = 2 cycles when not stalled.
//   Full throughput 1 word/cycle; backpressure holds S2 stable (out_data/out_last
//   must not change while out_valid & !out_ready). No word dropped or duplicated.
//  Arithmetic per lane: sum = {1'b0,pix} + sign_ext(beta) in 10 bits signed;
//   sum<0 -> 0; sum>255 -> 255; else sum[7:0]. Bypass: out = in exactly.
//  DRAIN -> IDLE when s1_valid=0 & s2_valid=0 after last word handshaked on out;
//   frame_done pulses in the cycle of that final out handshake.
//  Word with in_last=1 accepted while in_valid held: no further words accepted.
//  Reset mid-frame: pipeline contents discarded, no frame_done.
// STRUCTURE
//  Package brightness_pkg: state enum {IDLE,RUN,DRAIN}, PIX_W=8, LANES=4,
//   PIX_MAX=8'hFF, saturating-lane function prototype constants.
//  Sub-module bright_lane_sat: one combinational lane (pix, beta -> saturated pix),
//   instantiated LANES times by generate; FSM, pipe regs, counter in top.
// TESTING
//  1 beta=+16,en=1, word 32'h10_F8_00_80 -> out 32'h20_FF_10_90 2 cycles later.
//  2 beta=-32 (8'hE0), word 32'h10_20_40_FF -> 32'h00_00_20_DF; en=0 -> unchanged.
//  3 8-word frame, out_ready low cycles 3-5: all 8 words in order, out_data stable
//    while stalled, word_cnt=8, single frame_done on 8th out handshake.
//  4 cfg_we beta=+1 mid-frame (active +5): rest of frame uses +5; next frame +1;
//    cfg_we with frame_start same cycle -> new beta applied to that frame.
//  5 frame_start while RUN ignored; in_valid in IDLE -> in_ready=0, nothing out.
//  6 n_rst asserted with 2 words in pipe: outputs 0 immediately, IDLE, no frame_done.

Source files
------------

// File: rtl/brightness_pkg.sv
// Shared types and constants for the brightness stream controller.
// Contents:
//   state_t    frame sequencer states (IDLE, RUN, DRAIN)
//   PIX_W      bits per pixel lane
//   LANES      pixels per 32-bit word
//   WORD_W     word width (PIX_W * LANES)
//   SUM_W      width of the per-lane signed sum (pixel + offset, plus sign bit)
//   PIX_MIN/MAX  saturation limits for one lane
//   clamp_sum  saturates a SUM_W-bit two's complement sum into one pixel
package brightness_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = PIX_W * LANES;
  // One bit of headroom above the pixel range plus a sign bit; holds
  // -128..382 for an 8-bit pixel and an 8-bit signed offset.
  localparam int SUM_W  = PIX_W + 2;

  localparam logic [PIX_W-1:0] PIX_MIN = '0;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

  // Negative sums clamp to 0, sums with any bit above the pixel range set
  // clamp to PIX_MAX, everything else passes through unchanged.
  function automatic logic [PIX_W-1:0] clamp_sum(input logic [SUM_W-1:0] sum);
    if (sum[SUM_W-1])
      return PIX_MIN;
    else if (|sum[SUM_W-2:PIX_W])
      return PIX_MAX;
    else
      return sum[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/bright_lane_sat.sv
// One combinational brightness lane: adds a signed offset to an unsigned
// pixel and saturates the result to the pixel range.
// Ports:
//   pix   in   PIX_W   unsigned input pixel
//   beta  in   BETA_W  signed (two's complement) offset
//   res   out  PIX_W   saturated adjusted pixel
module bright_lane_sat
  import brightness_pkg::*;
#(
  parameter int BETA_W = 8
) (
  input  logic [PIX_W-1:0]  pix,
  input  logic [BETA_W-1:0] beta,
  output logic [PIX_W-1:0]  res
);

  logic [SUM_W-1:0] sum;

  always_comb begin
    // Zero-extend the pixel, sign-extend the offset, add in SUM_W bits.
    sum = {{(SUM_W-PIX_W){1'b0}}, pix} + {{(SUM_W-BETA_W){beta[BETA_W-1]}}, beta};
    res = clamp_sum(sum);
  end

endmodule

// File: rtl/brightness_stream_ctrl.sv
// Frame sequencer and 2-stage pipeline around a 4-lane saturating brightness
// datapath. The offset is copied from the pending config registers into the
// active registers only at frame start, so config writes never tear a frame.
//
// Handshake: a word moves across a port on a rising clock edge where both
// valid and ready are high. valid never depends on ready; once out_valid is
// high, out_data/out_last hold until the word is taken.
//
// Ports:
//   clk, n_rst            clock (rising edge), async active-low reset
//   cfg_we/cfg_beta/cfg_en  write pending offset and enable
//   frame_start           pulse: begin a frame (honoured only in IDLE)
//   in_valid/in_data/in_last/in_ready     input word stream
//   out_valid/out_data/out_last/out_ready output word stream
//   busy                  sequencer not idle
//   frame_done            pulse in the cycle the last word is taken
//   word_cnt              words accepted in current/last frame (saturating)
//   dbg_state             current sequencer state
module brightness_stream_ctrl
  import brightness_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int BETA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cfg_we,
  input  logic [BETA_W-1:0] cfg_beta,
  input  logic              cfg_en,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  word_cnt,
  output state_t            dbg_state
);

  state_t state, state_nxt;

  logic [BETA_W-1:0] pend_beta, act_beta, eff_beta;
  logic              pend_en, act_en;

  logic              s1_valid, s1_last, s2_valid, s2_last;
  logic [WORD_W-1:0] s1_data, s2_data, sat_data;

  logic adv1, adv2, in_fire, out_fire, start_go;

  // Stage 2 may load when empty or draining this cycle; stage 1 likewise.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = (state == RUN) && adv1;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;
  assign start_go = (state == IDLE) && frame_start;
  assign eff_beta = act_en ? act_beta : '0;

  assign out_valid  = s2_valid;
  assign out_data   = s2_data;
  assign out_last   = s2_last;
  assign frame_done = out_fire && s2_last;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // Sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (in_fire && in_last) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Config: a write coinciding with frame_start goes straight to the active
  // registers so that frame uses the freshly written value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_beta <= '0;
      pend_en   <= 1'b0;
      act_beta  <= '0;
      act_en    <= 1'b0;
    end else begin
      if (cfg_we) begin
        pend_beta <= cfg_beta;
        pend_en   <= cfg_en;
      end
      if (start_go) begin
        act_beta <= cfg_we ? cfg_beta : pend_beta;
        act_en   <= cfg_we ? cfg_en   : pend_en;
      end
    end
  end

  // Per-frame word counter, saturating at all-ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      word_cnt <= '0;
    else if (start_go)
      word_cnt <= '0;
    else if (in_fire && (word_cnt != '1))
      word_cnt <= word_cnt + 1'b1;
  end

  // Pipeline registers. Data registers load only with a valid word so the
  // output bus keeps the last word instead of picking up idle input values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_data <= in_data;
          s1_last <= in_last;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= sat_data;
          s2_last <= s1_last;
        end
      end
    end
  end

  // Lane datapath between the stages.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bright_lane_sat #(.BETA_W(BETA_W)) u_lane (
      .pix  (s1_data[l*PIX_W +: PIX_W]),
      .beta (eff_beta),
      .res  (sat_data[l*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_brightness_stream_ctrl.sv
// Directed bench for brightness_stream_ctrl. Drivers push expected words
// into exp_q as they issue stimulus; a negedge monitor pops and compares on
// every output handshake and checks that stalled outputs hold steady.
module tb_brightness_stream_ctrl;
  import brightness_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_beta = 8'h00;
  logic        cfg_en = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic [15:0] word_cnt;
  state_t      dbg_state;

  brightness_stream_ctrl #(.CNT_W(16), .BETA_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .cfg_we(cfg_we), .cfg_beta(cfg_beta), .cfg_en(cfg_en),
    .frame_start(frame_start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done), .word_cnt(word_cnt),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  logic        prev_stall = 1'b0;
  logic [32:0] held = '0;
  logic [32:0] e;

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, held[31:0]);
        check("stall_last", 32'(out_last), 32'(held[32]));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_last", 32'(out_last), 32'(e[32]));
          check("frame_done", 32'(frame_done), 32'(e[32]));
        end
        if (frame_done) fd_cnt++;
      end else if (frame_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_done_no_handshake: got 1 expected 0");
      end
      prev_stall = out_valid && !out_ready;
      held = {out_last, out_data};
    end
  end

  // Driver tasks (each returns 1 time unit after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] b, input logic en);
    cfg_beta = b;
    cfg_en   = en;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic start_frame(input logic with_cfg, input logic [7:0] b, input logic en);
    frame_start = 1'b1;
    if (with_cfg) begin
      cfg_we   = 1'b1;
      cfg_beta = b;
      cfg_en   = en;
    end
    tick();
    frame_start = 1'b0;
    cfg_we      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [31:0] exp);
    int waited;
    waited = 0;
    exp_q.push_back({last, exp});
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for word %h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy || (exp_q.size() != 0)), 32'd0);
  endtask

  int fd0;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    n_rst = 1'b1;
    tick();

    // 1: +16, two-cycle latency
    cfg_write(8'h10, 1'b1);
    start_frame(1'b0, 8'h00, 1'b0);
    check("t1_cnt_clr", 32'(word_cnt), 32'd0);
    check("t1_state_run", 32'(dbg_state), 32'(RUN));
    check("t1_busy", 32'(busy), 32'd1);
    send_word(32'h10F8_0080, 1'b1, 32'h20FF_1090);
    @(negedge clk);
    check("t1_lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_c2", 32'(out_valid), 32'd1);
    tick();
    wait_idle();
    check("t1_word_cnt", 32'(word_cnt), 32'd1);

    // 2: negative offset, bypass, extreme offsets
    cfg_write(8'hE0, 1'b1);
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h1020_40FF, 1'b1, 32'h0000_20DF);
    wait_idle();
    cfg_write(8'hE0, 1'b0);
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h1020_40FF, 1'b1, 32'h1020_40FF);
    wait_idle();
    cfg_write(8'h7F, 1'b1);
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h0080_81FF, 1'b1, 32'h7FFF_FFFF);
    wait_idle();
    cfg_write(8'h80, 1'b1);
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h7F80_8100, 1'b1, 32'h0000_0100);
    wait_idle();

    // 3: 8-word frame with backpressure
    cfg_write(8'h03, 1'b1);
    start_frame(1'b0, 8'h00, 1'b0);
    fd0 = fd_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_word({8'(i), 8'(16 * i), 8'hFE, 8'h00}, (i == 7),
                    {8'(i + 3), 8'(16 * i + 3), 8'hFF, 8'h03});
      end
      begin
        repeat (2) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("t3_word_cnt", 32'(word_cnt), 32'd8);
    check("t3_frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);

    // 4: config timing relative to frame start
    cfg_write(8'h05, 1'b1);
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h1020_3040, 1'b0, 32'h1525_3545);
    send_word(32'h0102_0304, 1'b0, 32'h0607_0809);
    cfg_write(8'h01, 1'b1);
    send_word(32'h1020_3040, 1'b0, 32'h1525_3545);
    send_word(32'hFCFD_FEFF, 1'b1, 32'hFFFF_FFFF);
    wait_idle();
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h1020_3040, 1'b1, 32'h1121_3141);
    wait_idle();
    start_frame(1'b1, 8'hFF, 1'b1);
    send_word(32'h0020_3040, 1'b1, 32'h001F_2F3F);
    wait_idle();

    // 5: frame_start ignored in RUN; input ignored in IDLE
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h0000_0001, 1'b0, 32'h0000_0000);
    check("t5_cnt_1", 32'(word_cnt), 32'd1);
    start_frame(1'b0, 8'h00, 1'b0);
    check("t5_ign_cnt", 32'(word_cnt), 32'd1);
    check("t5_ign_state", 32'(dbg_state), 32'(RUN));
    send_word(32'h8080_8080, 1'b1, 32'h7F7F_7F7F);
    wait_idle();
    check("t5_cnt_2", 32'(word_cnt), 32'd2);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_idle_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) tick();
    check("t5_idle_out_valid", 32'(out_valid), 32'd0);
    check("t5_idle_cnt", 32'(word_cnt), 32'd2);

    // 6: reset with words in the pipe
    cfg_write(8'h10, 1'b1);
    start_frame(1'b0, 8'h00, 1'b0);
    out_ready = 1'b0;
    send_word(32'h0102_0304, 1'b0, 32'h1112_1314);
    send_word(32'h0506_0708, 1'b0, 32'h1516_1718);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    fd0 = fd_cnt;
    #2;
    n_rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_data", out_data, 32'h0);
    check("t6_out_last", 32'(out_last), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_frame_done", 32'(frame_done), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    check("t6_word_cnt", 32'(word_cnt), 32'd0);
    repeat (2) tick();
    out_ready = 1'b1;
    n_rst = 1'b1;
    repeat (3) tick();
    check("t6_no_done", 32'(fd_cnt - fd0), 32'd0);
    check("t6_quiet", 32'(out_valid), 32'd0);
    // Config registers were cleared too, so the next frame is a bypass.
    start_frame(1'b0, 8'h00, 1'b0);
    send_word(32'h1020_3040, 1'b1, 32'h1020_3040);
    wait_idle();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
